// File: rtl/pipe_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mem_responder_if
// Purpose  : Valid/ready request/response bundle between the core's MEM stage
//            (master) and the data-memory responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_mem_responder_if #(
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/pipe_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mem_responder
// Purpose  : Single-outstanding word-addressed data memory slave with
//            programmable wait states, byte-lane stores and range errors.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  pipe_mem_responder_if.slave   bus
);

  localparam int         BE_W      = DATA_W / 8;
  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] WAIT_INIT = 8'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                mem_we;
  logic [DATA_W-1:0]   mem_wword;
  logic                addr_oor;

  // Storage is deliberately left out of reset so contents survive a core reset.
  logic [DATA_W-1:0]   mem [DEPTH];

  // Any upper address bit set, or an index past the last word, is an error.
  assign addr_oor = (bus.req_addr >= 32'(DEPTH));

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Merge enabled store lanes over the current word; disabled lanes keep old data.
  always_comb begin
    mem_wword = mem[addr_q];
    for (int i = 0; i < BE_W; i++) begin
      if (be_q[i]) mem_wword[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Next-state, request capture and response data selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr[AW-1:0];
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          if (addr_oor) begin
            // Bad address skips wait states and never touches memory.
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          if (we_q) begin
            mem_we  = 1'b1;
            rdata_d = '0;
          end else begin
            rdata_d = mem[addr_q];
          end
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory write; reset at the access edge suppresses the commit.
  always_ff @(posedge clk1) begin
    if (rst_n && mem_we) mem[addr_q] <= mem_wword;
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_mem_responder
// Purpose  : Directed plus randomized checks of pipe_mem_responder against a
//            word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_mem_responder;

  localparam int WS = 2;

  logic clk1 = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Reference model: words 0..15 are the only in-range addresses the bench uses.
  logic [31:0] mm [16];

  pipe_mem_responder_if #(.DATA_W(32)) bus ();
  pipe_mem_responder_if #(.DATA_W(32)) b0 ();

  pipe_mem_responder #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(WS)) dut (
    .clk1(clk1), .rst_n(rst_n), .bus(bus)
  );

  pipe_mem_responder #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clk1(clk1), .rst_n(rst_n), .bus(b0)
  );

  assign b0.rsp_ready = 1'b1;

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++)
      r = r | ((((be[i] ? wd : old) >> (8 * i)) & 32'hFF) << (8 * i));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Full transaction on the WS=2 responder with rsp_ready held high.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input string tag);
    logic [31:0] exp_d;
    bit          exp_e;
    int          lat;
    int          g;
    bit          busy_bad;
    exp_e = (addr >= 32'd1024);
    exp_d = 32'd0;
    if (!exp_e && !we) exp_d = mm[addr[3:0]];
    if (!exp_e && we)  mm[addr[3:0]] = merge(mm[addr[3:0]], wd, be);
    g = 0;
    while (!bus.req_ready && g < 20) begin tick(); g++; end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    tick();
    bus.req_valid = 1'b0;
    lat = 0;
    busy_bad = 1'b0;
    while (!bus.rsp_valid && lat < 300) begin
      if (bus.req_ready) busy_bad = 1'b1;
      tick();
      lat++;
    end
    chk({tag, "_lat"},   32'(lat), exp_e ? 32'd0 : 32'(WS + 1));
    chk({tag, "_rdata"}, bus.rsp_rdata, exp_d);
    chk({tag, "_err"},   32'(bus.rsp_err), 32'(exp_e));
    chk({tag, "_busy"},  32'(busy_bad), 32'd0);
    tick();
    chk({tag, "_done_v"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_done_r"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic wait_rsp();
    int g;
    g = 0;
    while (!bus.rsp_valid && g < 300) begin tick(); g++; end
  endtask

  initial begin
    logic [31:0] v0 [3];
    int acc [3];
    int k, r;
    bit pre;
    logic [31:0] a;

    rst_n = 1'b0;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_be = 0; bus.rsp_ready = 1'b1;
    b0.req_valid = 0; b0.req_we = 0; b0.req_addr = 0; b0.req_wdata = 0; b0.req_be = 0;
    repeat (3) tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Give every model word a known value.
    for (int i = 0; i < 16; i++) begin
      mm[i] = 32'd0;
      txn(1'b1, 32'(i), (i == 7) ? 32'h11223344 : ((i == 9) ? 32'd0 : $urandom), 4'hF, "init");
    end

    txn(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, "st5");
    txn(1'b0, 32'd5, 32'd0, 4'h0, "ld5");

    txn(1'b1, 32'd7, 32'hAABBCCDD, 4'b0101, "st7_part");
    txn(1'b0, 32'd7, 32'd0, 4'h0, "ld7_part");
    chk("ld7_model", mm[7], 32'h11BB33DD);

    txn(1'b1, 32'd3, 32'h55555555, 4'h0, "st3_be0");
    txn(1'b0, 32'd3, 32'd0, 4'h0, "ld3_be0");

    txn(1'b0, 32'd1024, 32'd0, 4'h0, "oor_1024");
    txn(1'b0, 32'h80000005, 32'd0, 4'h0, "oor_hi");
    txn(1'b1, 32'd1024, 32'h0BADF00D, 4'hF, "oor_st");
    txn(1'b1, 32'h80000000, 32'h0BADF00D, 4'hF, "oor_st_hi");
    txn(1'b0, 32'd0, 32'd0, 4'h0, "ld0_after_oor");
    txn(1'b1, 32'd0, 32'h01020304, 4'hF, "st0");
    txn(1'b0, 32'd0, 32'd0, 4'h0, "ld0");

    // Backpressure: response held while the requester stalls.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'd5;
    tick();
    bus.req_valid = 1'b0;
    wait_rsp();
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = ~bus.req_valid;
      tick();
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release_v", 32'(bus.rsp_valid), 32'd0);
    chk("bp_release_r", 32'(bus.req_ready), 32'd1);

    // Reset one edge after accepting a store: store must not commit.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'd9;
    bus.req_wdata = 32'hCAFEF00D; bus.req_be = 4'hF;
    tick();
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("rstw_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstw_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    repeat (4) tick();
    txn(1'b0, 32'd9, 32'd0, 4'h0, "ld9_after_rst");

    // Reset while a response is pending discards it.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'd5;
    tick();
    bus.req_valid = 1'b0;
    wait_rsp();
    chk("rstr_pend", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rstr_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstr_rdata", bus.rsp_rdata, 32'd0);
    chk("rstr_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 7) == 0)
        a = ($urandom_range(0, 1) == 0) ? 32'(1024 + $urandom_range(0, 300))
                                        : (32'h80000000 | 32'($urandom_range(0, 15)));
      else
        a = 32'($urandom_range(0, 15));
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rnd");
    end

    // Zero-wait-state responder: preload words 0..2, then stream loads.
    for (int i = 0; i < 3; i++) begin
      int g;
      v0[i] = $urandom;
      b0.req_valid = 1'b1; b0.req_we = 1'b1; b0.req_addr = 32'(i);
      b0.req_wdata = v0[i]; b0.req_be = 4'hF;
      tick();
      b0.req_valid = 1'b0;
      g = 0;
      while (!b0.rsp_valid && g < 20) begin tick(); g++; end
      tick();
    end
    b0.req_valid = 1'b1; b0.req_we = 1'b0; b0.req_addr = 32'd0;
    k = 0; r = 0;
    for (int c = 0; c < 14; c++) begin
      pre = b0.req_ready && b0.req_valid;
      tick();
      if (pre && k < 3) begin
        acc[k] = c;
        k++;
        if (k == 3) b0.req_valid = 1'b0;
        else        b0.req_addr = 32'(k);
      end
      if (b0.rsp_valid) begin
        if (r < 3) chk("ws0_rdata", b0.rsp_rdata, v0[r]);
        r++;
      end
    end
    chk("ws0_accepts", 32'(k), 32'd3);
    chk("ws0_resps",   32'(r), 32'd3);
    if (k == 3) begin
      chk("ws0_gap1", 32'(acc[1] - acc[0]), 32'd3);
      chk("ws0_gap2", 32'(acc[2] - acc[1]), 32'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
